// File: rtl/dcr_pkg.sv
// Shared constants and state encoding for the DCR loader.
package dcr_pkg;

  localparam int DCR_NUM_REGS = 16;
  localparam int DCR_SEL_W    = 4;
  localparam int DCR_DATA_W   = 8;
  localparam int DCR_CNT_W    = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    WRITE     = 3'd2,
    VERIFY    = 3'd3,
    DONE      = 3'd4
  } dcr_loader_state_t;

endpackage

// File: rtl/dcr_loader.sv
// DCR loader: accepts a (base, count) command, then streams one host byte per
// register into the DCR file, optionally reading each one back to check it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Ready depends only on the registered state, never on valid, and
// valid is ignored whenever ready is low (busy commands, data outside
// WAIT_DATA).
module dcr_loader
  import dcr_pkg::*;
#(
  parameter int VERIFY_EN = 1,
  parameter int NUM_REGS  = DCR_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DCR_SEL_W-1:0]  cmd_base,
  input  logic [DCR_CNT_W-1:0]  cmd_count,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DCR_DATA_W-1:0] wdata,
  output logic                  dcr_we,
  output logic [DCR_SEL_W-1:0]  dcr_sel,
  output logic [DCR_DATA_W-1:0] dcr_wdata,
  input  logic [DCR_DATA_W-1:0] dcr_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DCR_SEL_W-1:0]  err_sel,
  output dcr_loader_state_t     dbg_state
);

  // NUM_REGS is a power of two, so wrapping the index is a mask.
  localparam logic [DCR_SEL_W-1:0] SEL_MASK = DCR_SEL_W'(NUM_REGS - 1);

  dcr_loader_state_t     state_q, state_d;
  logic [DCR_SEL_W-1:0]  base_q, base_d;
  logic [DCR_CNT_W-1:0]  count_q, count_d;
  logic [DCR_CNT_W-1:0]  idx_q, idx_d;
  logic                  dcr_we_q, dcr_we_d;
  logic [DCR_SEL_W-1:0]  dcr_sel_q, dcr_sel_d;
  logic [DCR_DATA_W-1:0] dcr_wdata_q, dcr_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DCR_SEL_W-1:0]  err_sel_q, err_sel_d;

  logic [DCR_CNT_W-1:0]  idx_inc;
  logic [DCR_SEL_W-1:0]  wr_sel;
  dcr_loader_state_t     adv_state;

  assign idx_inc   = idx_q + DCR_CNT_W'(1);
  assign wr_sel    = (base_q + idx_q[DCR_SEL_W-1:0]) & SEL_MASK;
  assign adv_state = (idx_inc == count_q) ? DONE : WAIT_DATA;

  // Next-state and next-output decode; outputs are registered from the next state.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    idx_d       = idx_q;
    dcr_we_d    = 1'b0;
    dcr_sel_d   = dcr_sel_q;
    dcr_wdata_d = dcr_wdata_q;
    err_d       = err_q;
    err_sel_d   = err_sel_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          base_d    = cmd_base;
          count_d   = cmd_count;
          idx_d     = '0;
          err_d     = 1'b0;
          err_sel_d = '0;
          if (cmd_count == '0) begin
            state_d = DONE;
          end else if (int'(cmd_count) > NUM_REGS) begin
            err_d     = 1'b1;
            err_sel_d = cmd_base;
            state_d   = DONE;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        // dcr_wdata doubles as the latched byte used by the read-back compare.
        if (wdata_valid) begin
          dcr_wdata_d = wdata;
          dcr_sel_d   = wr_sel;
          dcr_we_d    = 1'b1;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        if (VERIFY_EN != 0) begin
          state_d = VERIFY;
        end else begin
          idx_d   = idx_inc;
          state_d = adv_state;
        end
      end
      VERIFY: begin
        if (dcr_rdata != dcr_wdata_q) begin
          err_d     = 1'b1;
          err_sel_d = dcr_sel_q;
          state_d   = DONE;
        end else begin
          idx_d   = idx_inc;
          state_d = adv_state;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset aborts any command and drops dcr_we at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      dcr_we_q    <= 1'b0;
      dcr_sel_q   <= '0;
      dcr_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      dcr_we_q    <= dcr_we_d;
      dcr_sel_q   <= dcr_sel_d;
      dcr_wdata_q <= dcr_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_sel_q   <= err_sel_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign wdata_ready = (state_q == WAIT_DATA);
  assign dcr_we      = dcr_we_q;
  assign dcr_sel     = dcr_sel_q;
  assign dcr_wdata   = dcr_wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_sel     = err_sel_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dcr_loader.sv
// Directed bench for dcr_loader: one instance with read-back (a), one without (b),
// each writing into a small DCR register file model.
module tb_dcr_loader;
  import dcr_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  logic rf_rst;
  assign rf_rst = ~reset_n;

  // ---------------- instance a (VERIFY_EN=1) ----------------
  logic cmd_valid_a, cmd_ready_a, wdata_valid_a, wdata_ready_a;
  logic [3:0] cmd_base_a, dcr_sel_a, err_sel_a;
  logic [4:0] cmd_count_a;
  logic [7:0] wdata_a, dcr_wdata_a, dcr_rdata_a;
  logic dcr_we_a, busy_a, done_a, err_a;
  dcr_loader_state_t st_a;
  logic force_bad;

  dcr_loader #(.VERIFY_EN(1), .NUM_REGS(16)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_base(cmd_base_a), .cmd_count(cmd_count_a),
    .wdata_valid(wdata_valid_a), .wdata_ready(wdata_ready_a), .wdata(wdata_a),
    .dcr_we(dcr_we_a), .dcr_sel(dcr_sel_a), .dcr_wdata(dcr_wdata_a), .dcr_rdata(dcr_rdata_a),
    .busy(busy_a), .done(done_a), .err(err_a), .err_sel(err_sel_a), .dbg_state(st_a)
  );

  // ---------------- instance b (VERIFY_EN=0) ----------------
  logic cmd_valid_b, cmd_ready_b, wdata_valid_b, wdata_ready_b;
  logic [3:0] cmd_base_b, dcr_sel_b, err_sel_b;
  logic [4:0] cmd_count_b;
  logic [7:0] wdata_b, dcr_wdata_b, dcr_rdata_b;
  logic dcr_we_b, busy_b, done_b, err_b;
  dcr_loader_state_t st_b;

  dcr_loader #(.VERIFY_EN(0), .NUM_REGS(16)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_base(cmd_base_b), .cmd_count(cmd_count_b),
    .wdata_valid(wdata_valid_b), .wdata_ready(wdata_ready_b), .wdata(wdata_b),
    .dcr_we(dcr_we_b), .dcr_sel(dcr_sel_b), .dcr_wdata(dcr_wdata_b), .dcr_rdata(dcr_rdata_b),
    .busy(busy_b), .done(done_b), .err(err_b), .err_sel(err_sel_b), .dbg_state(st_b)
  );

  // ---------------- DCR register files (active-high reset) ----------------
  logic [7:0] regs_a[16];
  logic [7:0] regs_b[16];
  int we_cnt_a = 0;

  always @(posedge clk or posedge rf_rst) begin
    if (rf_rst) begin
      for (int i = 0; i < 16; i++) regs_a[i] <= 8'h00;
    end else if (dcr_we_a) begin
      regs_a[dcr_sel_a] <= dcr_wdata_a;
    end
  end

  always @(posedge clk or posedge rf_rst) begin
    if (rf_rst) begin
      for (int i = 0; i < 16; i++) regs_b[i] <= 8'h00;
    end else if (dcr_we_b) begin
      regs_b[dcr_sel_b] <= dcr_wdata_b;
    end
  end

  always @(posedge clk) begin
    if (dcr_we_a) we_cnt_a <= we_cnt_a + 1;
  end

  assign dcr_rdata_a = force_bad ? 8'h00 : regs_a[dcr_sel_a];
  assign dcr_rdata_b = regs_b[dcr_sel_b];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];   // {sel, data} of each expected DCR write on instance a
  logic [7:0] tx[32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver for instance a ----------------
  // Issues one command (accept cycle = cycle 0), offers tx[] bytes whenever
  // wdata_ready is seen, checks every DCR write against exp_q, and returns in
  // the cycle done is seen. abort_write >= 0 asserts reset during that write.
  task automatic run_a(input logic [3:0] b, input logic [4:0] n, input int abort_write,
                       output int done_at, output int offered);
    int writes;
    logic [11:0] e;
    done_at = -1;
    offered = 0;
    writes  = 0;
    cmd_base_a    = b;
    cmd_count_a   = n;
    cmd_valid_a   = 1'b1;
    wdata_valid_a = 1'b1;
    check("cmd_ready_idle", {31'd0, cmd_ready_a}, 32'd1);
    for (int c = 1; c <= 80; c++) begin
      tick();
      cmd_valid_a = 1'b0;
      if (c == 1) check("busy_after_accept", {31'd0, busy_a}, 32'd1);
      if (dcr_we_a) begin
        if (writes == abort_write) begin
          reset_n = 1'b0;
          #1;
          check("rst_we_drop", {31'd0, dcr_we_a}, 32'd0);
          check("rst_sel", {28'd0, dcr_sel_a}, 32'd0);
          check("rst_wdata", {24'd0, dcr_wdata_a}, 32'd0);
          check("rst_busy", {31'd0, busy_a}, 32'd0);
          check("rst_done", {31'd0, done_a}, 32'd0);
          check("rst_state", {29'd0, st_a}, {29'd0, IDLE});
          wdata_valid_a = 1'b0;
          return;
        end
        writes++;
        e = 12'hfff;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check("write_sel_data", {20'd0, dcr_sel_a, dcr_wdata_a}, {20'd0, e});
      end
      if (done_a) begin
        done_at = c;
        break;
      end
      if (wdata_ready_a && offered < int'(n)) begin
        wdata_a = tx[offered];
        offered++;
      end
    end
    wdata_valid_a = 1'b0;
    check("done_seen", {31'd0, done_at >= 0 || abort_write >= 0}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d, o, w0, k, acc_cyc, hi;
    logic [7:0] snap[16];
    begin : watchdog
      fork
        begin
          #500000;
          $display("FAIL watchdog: simulation time limit reached");
          $fatal(1, "timeout");
        end
      join_none
    end
    reset_n = 1'b0;
    force_bad = 1'b0;
    cmd_valid_a = 0; cmd_base_a = 0; cmd_count_a = 0; wdata_valid_a = 0; wdata_a = 0;
    cmd_valid_b = 0; cmd_base_b = 0; cmd_count_b = 0; wdata_valid_b = 0; wdata_b = 0;
    tick(); tick();
    check("reset_state", {29'd0, st_a}, {29'd0, IDLE});
    check("reset_we", {31'd0, dcr_we_a}, 32'd0);
    check("reset_sel", {28'd0, dcr_sel_a}, 32'd0);
    check("reset_wdata", {24'd0, dcr_wdata_a}, 32'd0);
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    check("reset_done", {31'd0, done_a}, 32'd0);
    check("reset_err", {31'd0, err_a}, 32'd0);
    check("reset_err_sel", {28'd0, err_sel_a}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("ready_after_reset", {31'd0, cmd_ready_a}, 32'd1);

    // base=2, count=3, wdata_valid held high: done in cycle 10 after accept
    tx[0] = 8'hA1; tx[1] = 8'hB2; tx[2] = 8'hC3;
    exp_q.push_back({4'd2, 8'hA1}); exp_q.push_back({4'd3, 8'hB2}); exp_q.push_back({4'd4, 8'hC3});
    w0 = we_cnt_a;
    run_a(4'd2, 5'd3, -1, d, o);
    check("t1_done_cycle", d, 32'd10);
    check("t1_err", {31'd0, err_a}, 32'd0);
    check("t1_exp_left", exp_q.size(), 32'd0);
    check("t1_we_count", we_cnt_a - w0, 32'd3);
    check("t1_reg2", {24'd0, regs_a[2]}, 32'hA1);
    check("t1_reg3", {24'd0, regs_a[3]}, 32'hB2);
    check("t1_reg4", {24'd0, regs_a[4]}, 32'hC3);
    tick();
    check("t1_done_pulse", {31'd0, done_a}, 32'd0);
    check("t1_idle_busy", {31'd0, busy_a}, 32'd0);

    // base=14, count=4: index wraps 14,15,0,1
    for (int i = 0; i < 16; i++) snap[i] = regs_a[i];
    tx[0] = 8'h01; tx[1] = 8'h02; tx[2] = 8'h03; tx[3] = 8'h04;
    exp_q.push_back({4'd14, 8'h01}); exp_q.push_back({4'd15, 8'h02});
    exp_q.push_back({4'd0, 8'h03}); exp_q.push_back({4'd1, 8'h04});
    run_a(4'd14, 5'd4, -1, d, o);
    check("t2_done_cycle", d, 32'd13);
    check("t2_reg14", {24'd0, regs_a[14]}, 32'h01);
    check("t2_reg15", {24'd0, regs_a[15]}, 32'h02);
    check("t2_reg0", {24'd0, regs_a[0]}, 32'h03);
    check("t2_reg1", {24'd0, regs_a[1]}, 32'h04);
    for (int i = 2; i <= 13; i++) check("t2_unchanged", {24'd0, regs_a[i]}, {24'd0, snap[i]});
    tick();

    // read-back forced to 0x00 while 0x5A goes to index 7
    force_bad = 1'b1;
    tx[0] = 8'h5A; tx[1] = 8'h11; tx[2] = 8'h22;
    exp_q.push_back({4'd7, 8'h5A});
    w0 = we_cnt_a;
    run_a(4'd7, 5'd3, -1, d, o);
    check("t3_done_cycle", d, 32'd4);
    check("t3_err", {31'd0, err_a}, 32'd1);
    check("t3_err_sel", {28'd0, err_sel_a}, 32'd7);
    check("t3_bytes_taken", o, 32'd1);
    check("t3_we_count", we_cnt_a - w0, 32'd1);
    force_bad = 1'b0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wdata_ready_a) hi++;
    end
    check("t3_no_more_ready", hi, 32'd0);
    check("t3_err_sticky", {31'd0, err_a}, 32'd1);
    check("t3_reg7", {24'd0, regs_a[7]}, 32'h5A);

    // count=0: done one cycle after accept, err cleared by the accept
    w0 = we_cnt_a;
    run_a(4'd5, 5'd0, -1, d, o);
    check("t4_zero_done", d, 32'd1);
    check("t4_zero_err", {31'd0, err_a}, 32'd0);
    check("t4_zero_we", we_cnt_a - w0, 32'd0);
    tick();
    // count=17: count error
    run_a(4'd9, 5'd17, -1, d, o);
    check("t4_big_done", d, 32'd1);
    check("t4_big_err", {31'd0, err_a}, 32'd1);
    check("t4_big_err_sel", {28'd0, err_sel_a}, 32'd9);
    check("t4_big_we", we_cnt_a - w0, 32'd0);
    tick();

    // reset during WRITE of the 2nd of 3 registers
    tx[0] = 8'h31; tx[1] = 8'h32; tx[2] = 8'h33;
    exp_q.push_back({4'd10, 8'h31});
    run_a(4'd10, 5'd3, 1, d, o);
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_a) hi++;
    end
    check("t5_no_done_in_reset", hi, 32'd0);
    check("t5_reg11_suppressed", {24'd0, regs_a[11]}, 32'h00);
    reset_n = 1'b1;
    tick();
    check("t5_ready_after_reset", {31'd0, cmd_ready_a}, 32'd1);
    check("t5_done_after_reset", {31'd0, done_a}, 32'd0);
    exp_q.delete();
    tx[0] = 8'h41; tx[1] = 8'h42; tx[2] = 8'h43;
    exp_q.push_back({4'd10, 8'h41}); exp_q.push_back({4'd11, 8'h42}); exp_q.push_back({4'd12, 8'h43});
    run_a(4'd10, 5'd3, -1, d, o);
    check("t5_done_cycle", d, 32'd10);
    check("t5_err", {31'd0, err_a}, 32'd0);
    check("t5_reg10", {24'd0, regs_a[10]}, 32'h41);
    check("t5_reg12", {24'd0, regs_a[12]}, 32'h43);
    tick();

    // instance b: count=16, random data and random wdata_valid gaps
    for (int i = 0; i < 16; i++) tx[i] = 8'($urandom_range(0, 255));
    cmd_base_b = 4'd3; cmd_count_b = 5'd16; cmd_valid_b = 1'b1;
    check("t6_cmd_ready", {31'd0, cmd_ready_b}, 32'd1);
    k = 0; acc_cyc = -1; d = -1;
    for (int c = 1; c <= 400; c++) begin
      tick();
      cmd_valid_b = 1'b0;
      if (done_b) begin
        check("t6_last_latency", c - acc_cyc, 32'd2);
        d = c;
        break;
      end
      if (wdata_ready_b && acc_cyc >= 0) begin
        check("t6_latency", c - acc_cyc, 32'd2);
        acc_cyc = -1;
      end
      if (wdata_ready_b && k < 16) begin
        if ($urandom_range(0, 2) != 0) begin
          wdata_valid_b = 1'b1;
          wdata_b = tx[k];
          k++;
          acc_cyc = c;
        end else begin
          wdata_valid_b = 1'b0;
        end
      end else begin
        wdata_valid_b = 1'($urandom_range(0, 1));
        wdata_b = 8'($urandom_range(0, 255));
      end
    end
    wdata_valid_b = 1'b0;
    check("t6_done_seen", {31'd0, d > 0}, 32'd1);
    check("t6_bytes", k, 32'd16);
    check("t6_err", {31'd0, err_b}, 32'd0);
    for (int i = 0; i < 16; i++) check("t6_reg", {24'd0, regs_b[(3 + i) % 16]}, {24'd0, tx[i]});
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcr_loader.md
DCR_LOADER -- requirements
Module: dcr_loader

Interface
REQ-001 SHALL have parameter VERIFY_EN, default 1: 1 = read-back check after every write, 0 = no check.
REQ-002 SHALL have parameter NUM_REGS, default 16: size of the DCR register file; fixed power of two.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 cmd_valid  input  1  host presents a load command.
REQ-006 cmd_ready  output  1  loader accepts a command this cycle.
REQ-007 cmd_base  input  4  first DCR index to write.
REQ-008 cmd_count  input  5  number of registers to write, 0..31.
REQ-009 wdata_valid  input  1  host presents one data byte.
REQ-010 wdata_ready  output  1  loader accepts the data byte this cycle.
REQ-011 wdata  input  8  data byte for the current register.
REQ-012 dcr_we  output  1  write enable to the DCR.
REQ-013 dcr_sel  output  4  DCR register select, used for both write and read-back.
REQ-014 dcr_wdata  output  8  DCR write data.
REQ-015 dcr_rdata  input  8  DCR combinational read of dcr_sel.
REQ-016 busy  output  1  command in progress; high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse that ends every accepted command.
REQ-018 err  output  1  sticky error flag; cleared only when the next command is accepted.
REQ-019 err_sel  output  4  DCR index that failed read-back, or cmd_base on a count error.

Function
REQ-020 FSM states SHALL be: IDLE, WAIT_DATA, WRITE, VERIFY, DONE.
REQ-021 IDLE: cmd_ready=1; on cmd_valid, latch base and count, set idx=0, clear err and err_sel.
  - count==0 -> DONE, no writes.
  - count>NUM_REGS -> err=1, err_sel=cmd_base, then DONE, no writes.
  - otherwise -> WAIT_DATA.
REQ-022 WAIT_DATA: wdata_ready=1; on wdata_valid, latch wdata and go to WRITE; with no valid, stall indefinitely.
REQ-023 WRITE lasts exactly one cycle:
  - dcr_we=1, dcr_sel=(base+idx) mod NUM_REGS, dcr_wdata=latched byte.
  - next state VERIFY if VERIFY_EN=1, else the advance rule.
REQ-024 VERIFY lasts exactly one cycle:
  - dcr_we=0, dcr_sel unchanged from WRITE.
  - compare dcr_rdata to the latched byte.
  - mismatch: err=1, err_sel=dcr_sel, go to DONE; remaining bytes are not consumed.
  - match: advance rule.
REQ-025 Advance rule: idx+1; if idx+1==count go to DONE, else go to WAIT_DATA.
REQ-026 Index arithmetic SHALL wrap modulo NUM_REGS, e.g. base=14, count=4 writes indices 14,15,0,1.
REQ-027 DONE: done=1 for one cycle, then IDLE; cmd_ready=0 in DONE.
REQ-028 Per-register latency from wdata accept to the next wdata_ready: 3 cycles with VERIFY_EN=1, 2 with VERIFY_EN=0.
REQ-029 Timing of host signals:
  - cmd_valid while busy SHALL be ignored; no queuing.
  - wdata_valid outside WAIT_DATA SHALL be ignored.
REQ-030 Outside WRITE: dcr_we=0, dcr_wdata holds its last value, dcr_sel holds its last value.

Reset
REQ-031 reset_n low SHALL immediately force, regardless of clock:
  - state=IDLE, idx=0;
  - dcr_we=0, dcr_sel=0, dcr_wdata=0;
  - busy=0, done=0, err=0, err_sel=0.
REQ-032 Reset mid-command SHALL abort the command with no done pulse; a DCR write in flight is suppressed.
REQ-033 After reset_n deasserts, cmd_ready=1 on the first clock edge.

Structure
REQ-034 Shared package dcr_pkg SHALL hold:
  - DCR_NUM_REGS=16, DCR_SEL_W=4, DCR_DATA_W=8;
  - the state enum dcr_loader_state_t.
REQ-035 The block SHALL be a single module; no sub-module is needed.
REQ-036 The bench SHALL instantiate the existing DCR register file as the write target, with reset_n inverted for its active-high reset.

Verification
REQ-037 base=2, count=3, bytes 0xA1,0xB2,0xC3, wdata_valid held high:
  - writes to indices 2,3,4 with that data;
  - done exactly 10 cycles after command accept; err=0.
REQ-038 base=14, count=4, bytes 1,2,3,4: DCR[14]=1, DCR[15]=2, DCR[0]=3, DCR[1]=4; DCR[2..13] unchanged.
REQ-039 Bench forces dcr_rdata=0x00 while 0x5A is written to index 7:
  - err=1, err_sel=7, done pulses;
  - wdata_ready never reasserts for the remaining bytes.
REQ-040 Count boundaries:
  - count=0: done one cycle after accept, no dcr_we;
  - count=17: err=1, err_sel=cmd_base, no dcr_we.
REQ-041 Assert reset_n low during WRITE of the 2nd of 3 registers:
  - dcr_we drops immediately, no done pulse;
  - a new command then completes normally.
REQ-042 VERIFY_EN=0, count=16, random data with random wdata_valid gaps:
  - all 16 registers match the data sent;
  - 2 cycles per register with no gaps.
